cpu_dbu: RTL
============

Name: cpu_dbu

Overview:
- Debug unit for the single-cycle CPU. It is the control/observation end of the CPU's clk/rst interface.
- Gates CPU execution through a clock-enable, in either continuous-run or single-step mode.
- Drives read addresses into the register file and data memory, and selects the CPU datapath values to show.
- Presents the selected value on an 8-digit seven-segment display plus 16 LEDs. Sits between board switches/buttons and the CPU top.

Parameters:
- DB_CYCLES, 20'd1000000, number of consecutive stable samples a button needs before it counts as pressed or released.
- SCAN_DIV, 17'd100000, clock cycles each display digit stays active.
- ADDR_W, 8, width of the shared rf/mem debug read address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- succ  in  1  slide switch; 1 = continuous run
- step  in  1  button; each press executes one instruction
- inc  in  1  button; debug address +1
- dec  in  1  button; debug address -1
- sel  in  3  display source select
- m_rf  in  1  1 = memory, 0 = register file (applies when sel=0)
- cpu_run  out  1  CPU clock enable; CPU state updates only when 1
- dbg_addr  out  ADDR_W  read address to rf port 3 and data-memory debug port
- rf_data  in  32  register file debug read data
- m_data  in  32  memory debug read data
- pc, npc, ir, rd1, rd2, alu_out, mdr  in  32 each  CPU status values
- ctrl  in  12  CPU control signals
- led  out  16  status LEDs
- an  out  8  digit anodes, active-low
- seg  out  8  segments {dp,g..a}, active-low

Behaviour:
- Reset (synchronous, active-high): all outputs and state are cleared on the first clk edge with rst=1.
  - cpu_run=0, dbg_addr=0, display register=0, led=0, digit index=0, scan counter=0.
  - an=8'hFE, seg=8'hC0 (digit "0", dp off).
  - Synchronizers and debounce counters are cleared; a step pending at reset is discarded.
- Input conditioning:
  - succ, sel and m_rf each pass through a 2-flop synchronizer.
  - step, inc and dec each pass through btn_pulse: 2-flop sync, then debounce (level changes only after DB_CYCLES consecutive equal samples), then a one-cycle pulse on the debounced 0->1 transition.
  - A held button produces exactly one pulse.
- cpu_run is registered and computed as succ_s | step_p.
  - succ rises -> cpu_run=1 three cycles later and stays 1.
  - succ falls -> cpu_run=0 three cycles later.
  - With succ_s=0, each step pulse gives exactly one cpu_run=1 cycle, in the cycle after the pulse.
  - A step pulse while succ_s=1 has no additional effect.
- dbg_addr counter:
  - inc pulse -> +1, wrapping (2^ADDR_W-1)->0.
  - dec pulse -> -1, wrapping 0->(2^ADDR_W-1).
  - inc and dec pulses in the same cycle -> no change.
  - The counter is independent of cpu_run.
- Display register: updated every cycle, so the display shows its source 1 cycle late.
  - sel=0: m_rf ? m_data : rf_data
  - sel=1 pc, 2 npc, 3 ir, 4 rd1, 5 rd2, 6 alu_out, 7 mdr
- led (registered):
  - sel=0: {m_rf, 7'b0, dbg_addr} with ADDR_W=8; led[15] = m_rf.
  - sel!=0: {4'b0, ctrl}.
- Scanner:
  - The scan counter counts 0..SCAN_DIV-1; on wrap, the digit index advances 0..7 and wraps 7->0.
  - an = ~(1<<index).
  - seg = active-low hex encoding of display[4*index+3:4*index], dp=1 (off).
  - an and seg are registered together, so they never disagree.

Decomposition:
- Package dbu_pkg holds:
  - sel encodings (SEL_MEMRF..SEL_MDR)
  - the 16-entry hex-to-segment constant table
  - the reset constants for an and seg
- Sub-module btn_pulse (param DB_CYCLES; ports clk, rst, btn, pulse), instantiated 3x.

Test Plan (DB_CYCLES=4, SCAN_DIV=4 on the bench):
- rst held 2 cycles, then all inputs 0 -> cpu_run=0, dbg_addr=0, an=8'hFE, seg=8'hC0, led=0.
- succ=0; step high for 20 cycles -> exactly one cycle of cpu_run=1. Step with 2-cycle glitches -> no cpu_run pulse.
- dec press from addr 0 -> dbg_addr=8'hFF; then inc press -> 8'h00; simultaneous inc+dec presses -> unchanged.
- succ=1 -> cpu_run=1 from the 3rd cycle on; step press during run -> cpu_run stays 1; succ=0 -> cpu_run=0 three cycles later.
- sel=3, ir=32'h1234ABCD -> led=ctrl. Over 32 cycles the (an, seg) pairs are FE/0xA1 (D), FD/0xC6 (C), FB/0x83 (b), F7/0x88 (A), EF/0x99 (4), DF/0xB0 (3), BF/0xA4 (2), 7F/0xF9 (1), each held 4 cycles.
- sel=0, m_rf=1, m_data=32'hDEADBEEF, dbg_addr=5 -> display=DEADBEEF, led=16'h8005. Assert rst mid-scan -> next cycle an=8'hFE, dbg_addr=0, cpu_run=0.

Source files
------------

// File: rtl/dbu_pkg.sv
// Shared constants for the CPU debug unit.
//   - display source select encodings
//   - hex digit -> active-low seven-segment pattern table ({dp,g..a})
//   - reset values for the digit anodes and segments
package dbu_pkg;

  typedef enum logic [2:0] {
    SEL_MEMRF = 3'd0,
    SEL_PC    = 3'd1,
    SEL_NPC   = 3'd2,
    SEL_IR    = 3'd3,
    SEL_RD1   = 3'd4,
    SEL_RD2   = 3'd5,
    SEL_ALU   = 3'd6,
    SEL_MDR   = 3'd7
  } sel_e;

  // Digit 0 enabled, showing "0" with the decimal point off.
  localparam logic [7:0] AN_RST  = 8'hFE;
  localparam logic [7:0] SEG_RST = 8'hC0;

  // Active-low segments, bit 7 is dp (kept at 1 = off).
  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
    8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
    8'h80, 8'h90, 8'h88, 8'h83,   // 8 9 A b
    8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
  };

endpackage

// File: rtl/cpu_dbu_btn_pulse.sv
// Button conditioner: 2-flop synchronizer, debounce, rising-edge pulse.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   btn   : raw asynchronous button level
//   pulse : one-cycle pulse when the debounced level goes 0->1
// The debounced level only changes after DB_CYCLES consecutive samples that
// differ from it; any sample equal to the current level restarts the count.
module btn_pulse #(
  parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic [19:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= 20'd0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= 20'd0;
      end else if (cnt >= DB_CYCLES - 20'd1) begin
        // This is the DB_CYCLES-th differing sample: accept the new level.
        level <= sync2;
        cnt   <= 20'd0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_dbu.sv
// Debug unit for the single-cycle CPU.
//   clk, rst           : system clock, synchronous active-high reset
//   succ               : switch, 1 = continuous run
//   step, inc, dec     : buttons (single step, debug address +1 / -1)
//   sel, m_rf          : display source select; m_rf picks memory vs regfile
//   cpu_run            : CPU clock enable
//   dbg_addr           : shared regfile / data memory debug read address
//   rf_data, m_data    : debug read data
//   pc..mdr, ctrl      : CPU status values
//   led                : status LEDs
//   an, seg            : 8-digit seven-segment display, active-low
module cpu_dbu
  import dbu_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = 20'd1000000,
  parameter logic [16:0] SCAN_DIV  = 17'd100000,
  parameter int          ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              succ,
  input  logic              step,
  input  logic              inc,
  input  logic              dec,
  input  logic [2:0]        sel,
  input  logic              m_rf,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       rf_data,
  input  logic [31:0]       m_data,
  input  logic [31:0]       pc,
  input  logic [31:0]       npc,
  input  logic [31:0]       ir,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       mdr,
  input  logic [11:0]       ctrl,
  output logic [15:0]       led,
  output logic [7:0]        an,
  output logic [7:0]        seg
);

  localparam int LED_PAD = 15 - ADDR_W;

  // Level inputs: {succ, m_rf, sel}
  logic [4:0] lvl_s1;
  logic [4:0] lvl_s2;
  logic       succ_s;
  logic       m_rf_s;
  logic [2:0] sel_s;

  logic step_p;
  logic inc_p;
  logic dec_p;

  logic [31:0] disp_next;
  logic [31:0] disp;
  logic [16:0] scan_cnt;
  logic [2:0]  idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_s1 <= 5'd0;
      lvl_s2 <= 5'd0;
    end else begin
      lvl_s1 <= {succ, m_rf, sel};
      lvl_s2 <= lvl_s1;
    end
  end

  assign succ_s = lvl_s2[4];
  assign m_rf_s = lvl_s2[3];
  assign sel_s  = lvl_s2[2:0];

  btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_step (
    .clk(clk), .rst(rst), .btn(step), .pulse(step_p)
  );
  btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn(inc), .pulse(inc_p)
  );
  btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_dec (
    .clk(clk), .rst(rst), .btn(dec), .pulse(dec_p)
  );

  // Run enable and debug address counter. Simultaneous inc and dec cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_run  <= 1'b0;
      dbg_addr <= '0;
    end else begin
      cpu_run <= succ_s | step_p;
      if (inc_p && !dec_p) begin
        dbg_addr <= dbg_addr + ADDR_W'(1);
      end else if (dec_p && !inc_p) begin
        dbg_addr <= dbg_addr - ADDR_W'(1);
      end
    end
  end

  always_comb begin
    disp_next = 32'd0;
    case (sel_e'(sel_s))
      SEL_MEMRF: disp_next = m_rf_s ? m_data : rf_data;
      SEL_PC:    disp_next = pc;
      SEL_NPC:   disp_next = npc;
      SEL_IR:    disp_next = ir;
      SEL_RD1:   disp_next = rd1;
      SEL_RD2:   disp_next = rd2;
      SEL_ALU:   disp_next = alu_out;
      SEL_MDR:   disp_next = mdr;
      default:   disp_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= 32'd0;
      led  <= 16'd0;
    end else begin
      disp <= disp_next;
      if (sel_s == SEL_MEMRF) begin
        led <= {m_rf_s, {LED_PAD{1'b0}}, dbg_addr};
      end else begin
        led <= {4'd0, ctrl};
      end
    end
  end

  // Digit scanner. an and seg are both derived from the same idx in the
  // same register stage so a digit is never shown with a neighbour's value.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= 17'd0;
      idx      <= 3'd0;
      an       <= AN_RST;
      seg      <= SEG_RST;
    end else begin
      if (scan_cnt >= SCAN_DIV - 17'd1) begin
        scan_cnt <= 17'd0;
        idx      <= idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 17'd1;
      end
      an  <= ~(8'd1 << idx);
      seg <= SEG_HEX[disp[{idx, 2'b00} +: 4]];
    end
  end

endmodule
